// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: alignment check, byte-lane generation and a
// req/ack data-bus handshake with timeout, stalling the pipeline while busy.
module mem_access_unit #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [63:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic [63:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        acc_fault,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [2:0]       off_q;
    logic             is_load;

    logic             start;
    logic             misaligned;
    logic             illegal;
    logic             timeout_hit;
    logic [2:0]       off;
    logic [7:0]       be_base;

    // funct3[1:0] encodes the access size for both loads and stores
    always_comb begin
        start      = mem_valid & (MemRead | MemWrite);
        off        = addr[2:0];
        be_base    = 8'h01;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: be_base = 8'h01;
            2'b01: begin
                be_base    = 8'h03;
                misaligned = addr[0];
            end
            2'b10: begin
                be_base    = 8'h0F;
                misaligned = |addr[1:0];
            end
            default: begin
                be_base    = 8'hFF;
                misaligned = |addr[2:0];
            end
        endcase
        illegal = (MemRead & MemWrite)
                | (MemRead & (funct3 == 3'b111))
                | (MemWrite & funct3[2])
                | misaligned;
        timeout_hit = (counter == CNT_W'(TIMEOUT - 1));
        stall = (state == BUSY) | ((state == IDLE) & start & ~illegal);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            off_q     <= '0;
            is_load   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            read_data <= '0;
            done      <= 1'b0;
            acc_fault <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            done      <= 1'b0;
            acc_fault <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (illegal) begin
                            acc_fault <= 1'b1;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= MemWrite;
                            mem_addr  <= {addr[31:3], 3'b000};
                            mem_be    <= MemWrite ? (be_base << off) : 8'hFF;
                            mem_wdata <= MemWrite ? (store_data << {off, 3'b000}) : '0;
                            off_q     <= off;
                            is_load   <= MemRead;
                            counter   <= '0;
                            state     <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    counter <= counter + 1'b1;
                    // an ack in the timeout cycle still completes normally
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        if (is_load) begin
                            read_data <= mem_rdata >> {off_q, 3'b000};
                        end
                        state <= RESP;
                    end else if (timeout_hit) begin
                        mem_req   <= 1'b0;
                        done      <= 1'b1;
                        bus_err   <= 1'b1;
                        read_data <= '0;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    counter <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit, built with a short timeout
// so the bus-error path is reachable in a few cycles.
module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [63:0] store_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [63:0] read_data;
    logic        stall;
    logic        done;
    logic        acc_fault;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_valid  (mem_valid),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .read_data  (read_data),
        .stall      (stall),
        .done       (done),
        .acc_fault  (acc_fault),
        .bus_err    (bus_err)
    );

    typedef struct {
        logic        fault;
        logic        berr;
        logic        done;
        logic        is_store;
        logic [63:0] rdata;
        int          stall_cyc;
        int          req_cyc;
        logic [7:0]  be;
        logic        we;
        logic [31:0] addr;
        logic [63:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] model_rd = '0;

    int          obs_stall, obs_req;
    logic        obs_done, obs_fault, obs_berr, obs_hung, obs_stall_resp, obs_req_after;
    logic [63:0] obs_rd, obs_wdata;
    logic [7:0]  obs_be;
    logic        obs_we;
    logic [31:0] obs_addr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Reference behaviour of one access, given the bus reply the bench will give
    function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [63:0] sd,
                                   input int ack_at, input logic [63:0] rdata);
        exp_t       e;
        logic [2:0] o;
        logic       bad;
        logic [7:0] base;
        o    = a[2:0];
        base = (f3[1:0] == 2'd0) ? 8'h01 : (f3[1:0] == 2'd1) ? 8'h03 :
               (f3[1:0] == 2'd2) ? 8'h0F : 8'hFF;
        bad  = (rd && wr) || (rd && f3 == 3'b111) || (wr && f3[2]) ||
               (f3[1:0] == 2'd1 && a[0] != 1'b0) ||
               (f3[1:0] == 2'd2 && a[1:0] != 2'd0) ||
               (f3[1:0] == 2'd3 && a[2:0] != 3'd0);
        e.is_store = wr;
        e.be       = wr ? 8'(base << o) : 8'hFF;
        e.we       = wr;
        e.addr     = {a[31:3], 3'b000};
        e.wdata    = sd << (8 * o);
        e.fault    = bad;
        e.berr     = 1'b0;
        e.done     = 1'b0;
        e.rdata    = model_rd;
        e.stall_cyc = 0;
        e.req_cyc   = 0;
        if (!bad) begin
            e.done = 1'b1;
            if (ack_at < 1 || ack_at > TO) begin
                e.berr      = 1'b1;
                e.rdata     = '0;
                e.req_cyc   = TO;
                e.stall_cyc = TO + 1;
            end else begin
                e.req_cyc   = ack_at;
                e.stall_cyc = ack_at + 1;
                if (rd) e.rdata = rdata >> (8 * o);
            end
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [63:0] sd,
                                 input int ack_at, input logic [63:0] rdata);
        exp_t e;
        int   busy_idx;
        logic finished;
        e = model(rd, wr, f3, a, sd, ack_at, rdata);
        sb.push_back(e);
        model_rd = e.rdata;
        repeat (2) @(negedge clk);
        mem_valid  = 1'b1;
        MemRead    = rd;
        MemWrite   = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        mem_rdata  = 64'hDEAD_BEEF_0BAD_F00D;
        obs_stall = 0; obs_req = 0; obs_done = 0; obs_fault = 0; obs_berr = 0;
        obs_be = '0; obs_we = 1'b0; obs_addr = '0; obs_wdata = '0; obs_rd = '0;
        obs_stall_resp = 1'b1; obs_req_after = 1'b1;
        busy_idx = 0;
        finished = 1'b0;
        #1;
        if (stall) obs_stall++;
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            @(posedge clk);
            #1;
            if (done || acc_fault || bus_err) begin
                obs_done       = done;
                obs_fault      = acc_fault;
                obs_berr       = bus_err;
                obs_rd         = read_data;
                obs_stall_resp = stall;
                obs_req_after  = mem_req;
                finished       = 1'b1;
                mem_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
            end else begin
                if (mem_req) begin
                    busy_idx++;
                    obs_req++;
                    if (busy_idx == 1) begin
                        obs_be = mem_be; obs_we = mem_we; obs_addr = mem_addr; obs_wdata = mem_wdata;
                    end
                    mem_ack   = (busy_idx == ack_at);
                    mem_rdata = mem_ack ? rdata : 64'hDEAD_BEEF_0BAD_F00D;
                end else begin
                    mem_ack = 1'b0;
                end
                if (stall) obs_stall++;
            end
        end
        obs_hung = !finished;
        mem_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1'b1, 1'b0);
            return;
        end
        e = sb.pop_front();
        check({tag, "_hung"}, obs_hung, 1'b0);
        check({tag, "_done"}, obs_done, e.done);
        check({tag, "_fault"}, obs_fault, e.fault);
        check({tag, "_buserr"}, obs_berr, e.berr);
        check({tag, "_stall_cyc"}, 64'(obs_stall), 64'(e.stall_cyc));
        check({tag, "_req_cyc"}, 64'(obs_req), 64'(e.req_cyc));
        check({tag, "_read_data"}, obs_rd, e.rdata);
        check({tag, "_stall_end"}, obs_stall_resp, 1'b0);
        check({tag, "_req_end"}, obs_req_after, 1'b0);
        if (!e.fault) begin
            check({tag, "_be"}, obs_be, e.be);
            check({tag, "_we"}, obs_we, e.we);
            check({tag, "_addr"}, obs_addr, e.addr);
            if (e.is_store) check({tag, "_wdata"}, obs_wdata, e.wdata);
        end
    endtask

    initial begin
        rst = 1'b1; mem_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        funct3 = '0; addr = '0; store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", mem_req, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_be", mem_be, 8'h00);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 64'h0);
        check("rst_read_data", read_data, 64'h0);
        check("rst_stall", stall, 1'b0);
        check("rst_pulses", {done, acc_fault, bus_err}, 3'b000);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b1, 1'b0, 3'b011, 32'h100, '0, 3, 64'h1122_3344_5566_7788);
        checkOutput("ld");
        check("ld_lit", obs_rd, 64'h1122_3344_5566_7788);

        applyStimulus(1'b1, 1'b0, 3'b100, 32'h105, '0, 1, 64'hAABB_CCDD_EEFF_0011);
        checkOutput("lbu");
        check("lbu_lit", obs_rd, 64'h0000_0000_00AA_BBCC);

        applyStimulus(1'b1, 1'b0, 3'b010, 32'h104, '0, 2, 64'hAABB_CCDD_EEFF_0011);
        checkOutput("lw");
        check("lw_lit", obs_rd, 64'h0000_0000_AABB_CCDD);

        applyStimulus(1'b0, 1'b1, 3'b001, 32'h206, 64'h1234_5678_9ABC_BEEF, 1, '0);
        checkOutput("sh");
        check("sh_be_lit", obs_be, 8'hC0);
        check("sh_wdata_hi", obs_wdata[63:48], 16'hBEEF);
        check("sh_addr_lit", obs_addr, 32'h200);

        applyStimulus(1'b0, 1'b1, 3'b000, 32'h003, 64'h0000_0000_0000_00A5, 2, '0);
        checkOutput("sb");

        applyStimulus(1'b1, 1'b0, 3'b000, 32'h107, '0, 1, 64'h8877_6655_4433_2211);
        checkOutput("lb_odd");

        applyStimulus(1'b1, 1'b0, 3'b010, 32'h102, '0, 1, 64'h1);
        checkOutput("lw_misalign");
        applyStimulus(1'b0, 1'b1, 3'b011, 32'h104, 64'h55, 1, '0);
        checkOutput("sd_misalign");
        applyStimulus(1'b1, 1'b0, 3'b111, 32'h100, '0, 1, 64'h1);
        checkOutput("ld_f3_111");
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h100, 64'h1, 1, 64'h1);
        checkOutput("rd_and_wr");
        applyStimulus(1'b0, 1'b1, 3'b110, 32'h100, 64'h1, 1, '0);
        checkOutput("st_f3_bit2");

        applyStimulus(1'b1, 1'b0, 3'b011, 32'h108, '0, 0, 64'h1);
        checkOutput("timeout");

        applyStimulus(1'b1, 1'b0, 3'b011, 32'h110, '0, TO, 64'h0F0E_0D0C_0B0A_0908);
        checkOutput("ack_at_timeout");

        // Reset lands in the second BUSY cycle, then a stale ack follows
        repeat (2) @(negedge clk);
        mem_valid = 1'b1; MemRead = 1'b1; funct3 = 3'b011; addr = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_busy_req", mem_req, 1'b1);
        rst = 1'b1; mem_valid = 1'b0; MemRead = 1'b0;
        @(posedge clk); #1;
        check("rst_drop_req", mem_req, 1'b0);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check("late_ack_done", done, 1'b0);
        check("late_ack_rd", read_data, 64'h0);
        check("late_ack_req", mem_req, 1'b0);
        @(posedge clk); #1;
        check("late_ack_done2", done, 1'b0);
        check("late_ack_stall", stall, 1'b0);

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
